// File: rtl/ctx_xfer_seq.sv
// Context transfer bus master: copies the register file into the peripheral GPR
// window (save) or back from it (restore), one word per granted cycle.
module ctx_xfer_seq #(
    parameter logic [31:0] BASE_ADDR = 32'hffffc000,
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dir,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_IDX = FIRST_REG[4:0];
    localparam logic [4:0] LAST_IDX  = LAST_REG[4:0];

    state_t     state, state_nx;
    logic [4:0] idx, idx_nx;
    logic       dir_q, dir_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= FIRST_IDX;
            dir_q <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            dir_q <= dir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        dir_nx   = dir_q;
        busy     = (state != IDLE);
        done     = 1'b0;
        bus_req  = 1'b0;
        rf_addr  = 5'd0;
        rf_we    = 1'b0;
        rf_wdata = 32'd0;
        mem_we   = 1'b0;
        mem_addr = 32'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    dir_nx   = dir;
                    idx_nx   = FIRST_IDX;
                    state_nx = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_nx = XFER;
            end
            XFER: begin
                bus_req = 1'b1;
                // A revoked grant leaves idx untouched so the word is retried later.
                if (bus_gnt) begin
                    mem_addr = BASE_ADDR + {25'd0, idx, 2'b00};
                    rf_addr  = idx;
                    if (dir_q) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_data;
                    end else begin
                        mem_we = 1'b1;
                    end
                    if (idx == LAST_IDX) state_nx = FIN;
                    else                 idx_nx   = idx + 5'd1;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only drive the shared bus on a save beat so the peripheral read drive never contends.
    assign mem_data = mem_we ? rf_rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_ctx_xfer_seq.sv
// Self-checking bench for ctx_xfer_seq: scenario table, reset/strobe corner cases
// and randomized grant/start traffic checked cycle by cycle against a transfer model.
module tb_ctx_xfer_seq;

    localparam logic [31:0] BASE  = 32'hffffc000;
    localparam int          FIRST = 1;
    localparam int          LAST  = 31;
    localparam int          NXFER = LAST - FIRST + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        bus_gnt = 1'b0;
    logic        busy, done, bus_req, rf_we, mem_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata, rf_wdata, mem_addr;
    wire  [31:0] mem_data;

    logic [31:0] rf_m [32];
    logic [31:0] pmem [32];

    int checks = 0;
    int errors = 0;

    // transfer model
    bit m_active, m_seen, m_dir;
    int m_cnt;
    int done_seen, we_seen, rfwe_seen;

    always #5 clk = ~clk;

    ctx_xfer_seq #(.BASE_ADDR(BASE), .FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    assign rf_rdata = rf_m[rf_addr];

    wire       p_sel = (mem_addr[31:7] == BASE[31:7]);
    wire [4:0] p_idx = mem_addr[6:2];
    assign mem_data = (p_sel && !mem_we) ? pmem[p_idx] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (rf_we) rf_m[rf_addr] = rf_wdata;
        if (mem_we && p_sel) pmem[p_idx] = mem_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic g, input logic s, input logic d, input logic r);
        bit          x;
        logic [31:0] e_addr;
        int          i;
        @(negedge clk);
        bus_gnt = g; start = s; dir = d; rst = r;
        #1;
        i = FIRST + m_cnt;
        x = m_active && m_cnt < NXFER && m_seen && g;
        e_addr = x ? BASE + 32'(i * 4) : 32'd0;
        chk("busy",    {31'd0, busy},    {31'd0, m_active});
        chk("done",    {31'd0, done},    {31'd0, m_active && m_cnt == NXFER});
        chk("bus_req", {31'd0, bus_req}, {31'd0, m_active && m_cnt < NXFER});
        chk("mem_we",  {31'd0, mem_we},  {31'd0, x && !m_dir});
        chk("rf_we",   {31'd0, rf_we},   {31'd0, x && m_dir});
        chk("mem_addr", mem_addr, e_addr);
        chk("rf_addr", {27'd0, rf_addr}, x ? 32'(i) : 32'd0);
        chk("rf_wdata", rf_wdata, (x && m_dir) ? pmem[i] : 32'd0);
        if (x && !m_dir) chk("mem_data", mem_data, rf_m[i]);
        if (done === 1'b1)   done_seen++;
        if (mem_we === 1'b1) we_seen++;
        if (rf_we === 1'b1)  rfwe_seen++;
        if (r) begin
            m_active = 0; m_seen = 0; m_cnt = 0; m_dir = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1; m_seen = 0; m_cnt = 0; m_dir = d;
            end
        end else if (m_cnt == NXFER) begin
            m_active = 0;
        end else begin
            if (x) m_cnt++;
            if (g) m_seen = 1;
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 32; i++) begin
            rf_m[i] = 32'hA5000000 + 32'(i);
            pmem[i] = ~32'(i);
        end
    endtask

    typedef struct {
        logic dir;
        int   late;
        int   drop_at;
        int   drop_len;
        int   flip_at;
        int   exp_done;
    } vec_t;

    vec_t vecs[6];

    // Runs one command from start to done; returns the cycle (after the start edge) of done.
    task automatic run_op(input vec_t v, output int done_k);
        int drop_left;
        bit g;
        done_k = -1;
        drop_left = v.drop_len;
        done_seen = 0; we_seen = 0; rfwe_seen = 0;
        step(1'b0, 1'b1, v.dir, 1'b0);
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            g = (k > v.late);
            if (drop_left > 0 && m_seen && m_cnt == v.drop_at - FIRST) begin
                g = 1'b0;
                drop_left--;
            end
            step(g, k == v.flip_at, ~v.dir, 1'b0);
            if (done === 1'b1) done_k = k;
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int dk;
        fill_default();
        vecs[0] = '{dir: 1'b0, late: 0, drop_at: 0,  drop_len: 0, flip_at: 0, exp_done: 33};
        vecs[1] = '{dir: 1'b1, late: 0, drop_at: 0,  drop_len: 0, flip_at: 0, exp_done: 33};
        vecs[2] = '{dir: 1'b0, late: 0, drop_at: 10, drop_len: 4, flip_at: 0, exp_done: 37};
        vecs[3] = '{dir: 1'b0, late: 7, drop_at: 0,  drop_len: 0, flip_at: 0, exp_done: 40};
        vecs[4] = '{dir: 1'b1, late: 0, drop_at: 0,  drop_len: 0, flip_at: 5, exp_done: 33};
        vecs[5] = '{dir: 1'b1, late: 3, drop_at: 31, drop_len: 2, flip_at: 0, exp_done: 38};

        // reset, including a start strobe coincident with reset
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 6; v++) begin
            fill_default();
            run_op(vecs[v], dk);
            chk($sformatf("done_cycle[%0d]", v), 32'(dk), 32'(vecs[v].exp_done));
            chk($sformatf("done_count[%0d]", v), 32'(done_seen), 32'd1);
            chk($sformatf("we_count[%0d]", v), 32'(we_seen), vecs[v].dir ? 32'd0 : 32'(NXFER));
            chk($sformatf("rfwe_count[%0d]", v), 32'(rfwe_seen), vecs[v].dir ? 32'(NXFER) : 32'd0);
            if (!vecs[v].dir) begin
                chk($sformatf("gpr0_untouched[%0d]", v), pmem[0], 32'hffffffff);
                chk($sformatf("gpr31[%0d]", v), pmem[31], 32'hA500001F);
            end else begin
                chk($sformatf("rf7[%0d]", v), rf_m[7], ~32'd7);
            end
        end

        // reset in the middle of a save, on the idx 15 beat
        fill_default();
        done_seen = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 100 && m_cnt != 15 - FIRST; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reached_idx15", 32'(m_cnt), 32'(15 - FIRST));
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_no_done", 32'(done_seen), 32'd0);
        chk("rst_partial_gpr20", pmem[20], ~32'd20);
        run_op(vecs[0], dk);
        chk("after_rst_done_cycle", 32'(dk), 32'd33);
        chk("after_rst_writes", 32'(we_seen), 32'(NXFER));

        // randomized traffic with random grant, strobes, directions and resets
        for (int i = 0; i < 32; i++) begin
            rf_m[i] = $urandom;
            pmem[i] = $urandom;
        end
        done_seen = 0;
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
        end
        chk("random_some_done", 32'(done_seen > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
